// File: rtl/sched_pkg.sv
// Shared definitions for the quantum scheduler: default sizing, the
// scheduler state encoding and the derived pid width.
package sched_pkg;

  localparam int NPROC_DEF = 8;
  localparam int QW_DEF    = 16;
  localparam int QDEF_DEF  = 100;
  localparam int PID_W     = $clog2(NPROC_DEF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_EXPIRE = 2'd2,
    ST_SWITCH = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: finds the first set bit of the ready
// mask starting just after the base slot, wrapping, with the base slot
// itself considered last.
module rr_picker
  import sched_pkg::*;
#(
  parameter int NPROC = NPROC_DEF
) (
  input  logic [NPROC-1:0]         i_mask,
  input  logic [$clog2(NPROC)-1:0] i_base,
  output logic [$clog2(NPROC)-1:0] o_pid,
  output logic                     o_valid
);

  localparam int PW = $clog2(NPROC);

  logic [PW-1:0] w_idx;

  // Walk base+1 .. base+NPROC; the last step wraps back onto the base slot
  // because NPROC is a power of two and the index simply overflows.
  always_comb begin
    o_pid   = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= NPROC; i++) begin
      w_idx = i_base + PW'(i);
      if (!o_valid && i_mask[w_idx]) begin
        o_pid   = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/quantum_scheduler.sv
// Quantum-based preemptive scheduler: counts retired user instructions
// against a programmable quantum, raises a preemption request when the
// quantum runs out or the process halts, and keeps a registered
// round-robin candidate for the next dispatch.
module quantum_scheduler
  import sched_pkg::*;
#(
  parameter int NPROC = NPROC_DEF,
  parameter int QW    = QW_DEF,
  parameter int QDEF  = QDEF_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     set_quantum,
  input  logic [QW-1:0]            quantum_in,
  input  logic                     retire,
  input  logic                     start,
  input  logic                     exit,
  input  logic                     int_ack,
  input  logic                     ready_set,
  input  logic [$clog2(NPROC)-1:0] ready_pid,
  output logic                     int_req,
  output logic [$clog2(NPROC)-1:0] cur_pid,
  output logic [$clog2(NPROC)-1:0] next_pid,
  output logic                     next_valid,
  output logic [QW-1:0]            remaining
);

  localparam int PW = $clog2(NPROC);

  sched_state_t r_state;
  sched_state_t w_stateNext;

  logic [QW-1:0]    r_quantum;
  logic [QW-1:0]    r_remaining;
  logic [PW-1:0]    r_curPid;
  logic [PW-1:0]    r_nextPid;
  logic             r_nextValid;
  logic [NPROC-1:0] r_readyMask;
  logic [NPROC-1:0] w_maskNext;

  logic             w_load;
  logic             w_dec;
  logic             w_exitClr;
  logic [PW-1:0]    w_pickPid;
  logic             w_pickValid;

  rr_picker #(
    .NPROC (NPROC)
  ) u_picker (
    .i_mask  (r_readyMask),
    .i_base  (r_curPid),
    .o_pid   (w_pickPid),
    .o_valid (w_pickValid)
  );

  // State register; reset lands in IDLE so the request drops at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic plus the strobes that steer the datapath registers.
  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_exitClr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && r_nextValid) begin
          w_load      = 1'b1;
          w_stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        if (exit) begin
          w_exitClr   = 1'b1;
          w_stateNext = ST_EXPIRE;
        end else if (retire && (r_remaining != '0)) begin
          w_dec = 1'b1;
          if (r_remaining == QW'(1)) begin
            w_stateNext = ST_EXPIRE;
          end
        end
      end
      ST_EXPIRE: begin
        if (int_ack) begin
          w_stateNext = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Ready mask update; a halting process's clear overrides a same-slot set.
  always_comb begin
    w_maskNext = r_readyMask;
    if (ready_set) begin
      w_maskNext[ready_pid] = 1'b1;
    end
    if (w_exitClr) begin
      w_maskNext[r_curPid] = 1'b0;
    end
  end

  // Quantum register, reloadable at any time; only future dispatches see it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_quantum <= QW'(QDEF);
    end else if (set_quantum) begin
      r_quantum <= quantum_in;
    end
  end

  // Current pid and remaining count: loaded on dispatch, counted down on retire.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_curPid    <= '0;
      r_remaining <= '0;
    end else if (w_load) begin
      r_curPid    <= r_nextPid;
      r_remaining <= r_quantum;
    end else if (w_dec) begin
      r_remaining <= r_remaining - QW'(1);
    end
  end

  // Ready mask register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_readyMask <= '0;
    end else begin
      r_readyMask <= w_maskNext;
    end
  end

  // Registered round-robin candidate, refreshed every cycle from current state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_nextPid   <= '0;
      r_nextValid <= 1'b0;
    end else begin
      r_nextPid   <= w_pickPid;
      r_nextValid <= w_pickValid;
    end
  end

  assign int_req    = (r_state == ST_EXPIRE);
  assign cur_pid    = r_curPid;
  assign next_pid   = r_nextPid;
  assign next_valid = r_nextValid;
  assign remaining  = r_remaining;

endmodule
